uc_runctl: RTL and testbench

- Control unit and run controller for the single-cycle microc datapath.
- Decodes Opcode and flag z into the datapath control lines: s_inc, s_inm, we3, wez, Op.
- Adds run/stop/single-step sequencing, illegal-opcode trapping, a retired-instruction counter and an optional instruction budget.
- Drives pc_we, the PC write-enable port on the microc datapath revision. Holding pc_we=0 freezes the PC.

---
 rtl/uc_runctl.sv | 127 ++++++++++++
 tb/tb_uc_runctl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_runctl.sv
// rtl/uc_runctl.sv - microc control unit with run/stop/step sequencing, illegal-opcode trap and instruction counter
module uc_runctl #(
  parameter int CNT_W     = 16,
  parameter int MAX_INSTR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             clear_err,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_we,
  output logic             running,
  output logic             halted,
  output logic             illegal,
  output logic             step_done,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, STEP, ERR} state_t;

  localparam logic             HAS_BUDGET  = (MAX_INSTR != 0);
  localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(MAX_INSTR - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

  state_t state, state_nx;
  logic   step_armed;
  logic   exec;
  logic   is_ill;
  logic   retire;
  logic   budget_hit;

  assign exec       = (state == RUN) || (state == STEP);
  assign is_ill     = (Opcode[5:4] == 2'b01);
  assign retire     = exec && !is_ill;
  assign budget_hit = HAS_BUDGET && (instr_cnt == BUDGET_LAST);
  assign running    = (state == RUN);
  assign halted     = (state == ERR);

  // Decode is gated by exec so reset or a trap drops all write enables combinationally.
  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    Op    = 3'b000;
    pc_we = 1'b0;
    if (retire) begin
      pc_we = 1'b1;
      if (Opcode[5]) begin
        we3 = 1'b1;
        wez = 1'b1;
        Op  = Opcode[4:2];
      end else if (Opcode[5:2] == 4'b0000) begin
        s_inm = 1'b1;
        we3   = 1'b1;
      end else begin
        case (Opcode[1:0])
          2'b00:   s_inc = 1'b0;
          2'b01:   s_inc = ~z;
          2'b10:   s_inc = z;
          default: s_inc = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start)
          state_nx = RUN;
        else if (step && step_armed)
          state_nx = STEP;
      end
      RUN: begin
        if (is_ill)
          state_nx = ERR;
        else if (budget_hit || stop)
          state_nx = IDLE;
      end
      STEP:    state_nx = is_ill ? ERR : IDLE;
      ERR:     if (clear_err) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      illegal    <= 1'b0;
      step_done  <= 1'b0;
      step_armed <= 1'b1;
      instr_cnt  <= '0;
    end else begin
      state     <= state_nx;
      step_done <= (state == STEP) && !is_ill;

      if (exec && is_ill)
        illegal <= 1'b1;
      else if ((state == ERR) && clear_err)
        illegal <= 1'b0;

      // A step is consumed only once; it re-arms after step is seen low in IDLE.
      if (state == IDLE) begin
        if (!step)
          step_armed <= 1'b1;
        else if (!start && step_armed)
          step_armed <= 1'b0;
      end

      if ((state == IDLE) && start)
        instr_cnt <= '0;
      else if (retire && (instr_cnt != CNT_SAT))
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uc_runctl.sv
// tb/tb_uc_runctl.sv - randomized and directed self-checking bench for uc_runctl against a behavioural model
module tb_uc_runctl;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0;
  logic       z = 1'b0;
  logic       start = 1'b0, stop = 1'b0, step = 1'b0, clear_err = 1'b0;

  logic       s_inc [NI];
  logic       s_inm [NI];
  logic       we3   [NI];
  logic       wez   [NI];
  logic [2:0] op_o  [NI];
  logic       pc_we [NI];
  logic       running [NI];
  logic       halted  [NI];
  logic       illegal [NI];
  logic       step_done [NI];
  logic [15:0] cnt0, cnt1;
  logic [2:0]  cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uc_runctl #(.CNT_W(16), .MAX_INSTR(0)) d0 (
    .clk(clk), .reset(reset), .Opcode(opcode), .z(z), .start(start), .stop(stop),
    .step(step), .clear_err(clear_err), .s_inc(s_inc[0]), .s_inm(s_inm[0]), .we3(we3[0]),
    .wez(wez[0]), .Op(op_o[0]), .pc_we(pc_we[0]), .running(running[0]), .halted(halted[0]),
    .illegal(illegal[0]), .step_done(step_done[0]), .instr_cnt(cnt0));

  uc_runctl #(.CNT_W(16), .MAX_INSTR(5)) d1 (
    .clk(clk), .reset(reset), .Opcode(opcode), .z(z), .start(start), .stop(stop),
    .step(step), .clear_err(clear_err), .s_inc(s_inc[1]), .s_inm(s_inm[1]), .we3(we3[1]),
    .wez(wez[1]), .Op(op_o[1]), .pc_we(pc_we[1]), .running(running[1]), .halted(halted[1]),
    .illegal(illegal[1]), .step_done(step_done[1]), .instr_cnt(cnt1));

  uc_runctl #(.CNT_W(3), .MAX_INSTR(0)) d2 (
    .clk(clk), .reset(reset), .Opcode(opcode), .z(z), .start(start), .stop(stop),
    .step(step), .clear_err(clear_err), .s_inc(s_inc[2]), .s_inm(s_inm[2]), .we3(we3[2]),
    .wez(wez[2]), .Op(op_o[2]), .pc_we(pc_we[2]), .running(running[2]), .halted(halted[2]),
    .illegal(illegal[2]), .step_done(step_done[2]), .instr_cnt(cnt2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 run, 2 single step, 3 error.
  int m_mode [NI];
  int m_cnt  [NI];
  int m_ill  [NI];
  int m_sd   [NI];
  int m_arm  [NI];
  int m_w    [NI] = '{16, 16, 3};
  int m_max  [NI] = '{0, 5, 0};

  function automatic logic [31:0] obs_vec(int k);
    logic [15:0] c;
    c = (k == 0) ? cnt0 : (k == 1) ? cnt1 : {13'b0, cnt2};
    return {4'b0, c, s_inc[k], s_inm[k], we3[k], wez[k], op_o[k], pc_we[k],
            running[k], halted[k], illegal[k], step_done[k]};
  endfunction

  function automatic logic [31:0] exp_vec(int k);
    int si = 1, sm = 0, w3 = 0, wz = 0, alu = 0, pw = 0;
    int o = opcode;
    bit executing = (m_mode[k] == 1) || (m_mode[k] == 2);
    bit bad = (o >= 16) && (o < 32);
    if (executing && !bad) begin
      pw = 1;
      if (o >= 32) begin
        w3 = 1; wz = 1; alu = (o / 4) % 8;
      end else if (o < 4) begin
        sm = 1; w3 = 1;
      end else if (o == 4) si = 0;
      else if (o == 5) si = z ? 0 : 1;
      else if (o == 6) si = z ? 1 : 0;
    end
    return {4'b0, 16'(m_cnt[k]), 1'(si), 1'(sm), 1'(w3), 1'(wz), 3'(alu), 1'(pw),
            1'(m_mode[k] == 1), 1'(m_mode[k] == 3), 1'(m_ill[k]), 1'(m_sd[k])};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_mode[k] = 0; m_cnt[k] = 0; m_ill[k] = 0; m_sd[k] = 0; m_arm[k] = 1;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      int  md  = m_mode[k];
      bit  ex  = (md == 1) || (md == 2);
      bit  bad = (opcode[5:4] == 2'b01);
      bit  hit = (m_max[k] != 0) && (m_cnt[k] == m_max[k] - 1);
      int  arm = m_arm[k];
      m_sd[k] = (md == 2) && !bad;
      if (ex && bad) m_ill[k] = 1;
      else if (md == 3 && clear_err) m_ill[k] = 0;
      if (md == 0 && start) m_cnt[k] = 0;
      else if (ex && !bad && m_cnt[k] < (1 << m_w[k]) - 1) m_cnt[k]++;
      if (md == 0) begin
        if (!step) m_arm[k] = 1;
        else if (!start && arm != 0) m_arm[k] = 0;
      end
      case (md)
        0: m_mode[k] = start ? 1 : (step && arm != 0) ? 2 : 0;
        1: m_mode[k] = bad ? 3 : (hit || stop) ? 0 : 1;
        2: m_mode[k] = bad ? 3 : 0;
        default: m_mode[k] = clear_err ? 0 : 3;
      endcase
    end
  endtask

  // Small microc datapath driven by d0's control lines, for the program run.
  bit          prog_mode = 0;
  int          pc = 0;
  logic [15:0] rf [16];
  logic        dp_z = 1'b0;
  logic [5:0]  p_op [16];
  int          p_imm [16];
  int          p_ra [16];
  int          p_rb [16];
  int          p_rd [16];
  logic [31:0] cap [NI];

  function automatic logic [15:0] alu_f(logic [2:0] f, logic [15:0] a, logic [15:0] b);
    case (f)
      3'b010:  return a + b;
      3'b011:  return a - b;
      default: return a & b;
    endcase
  endfunction

  task automatic set_prog(int a, logic [5:0] o, int imm, int ra, int rb, int rd);
    p_op[a] = o; p_imm[a] = imm; p_ra[a] = ra; p_rb[a] = rb; p_rd[a] = rd;
  endtask

  task automatic adv();
    model_step();
    if (prog_mode && cap[0][4]) begin
      logic [15:0] r;
      r = alu_f(cap[0][7:5], rf[p_ra[pc]], rf[p_rb[pc]]);
      if (cap[0][9]) rf[p_rd[pc]] = cap[0][10] ? 16'(p_imm[pc]) : r;
      if (cap[0][8]) dp_z = (r == 16'h0);
      pc = cap[0][11] ? pc + 1 : p_imm[pc];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      cap[k] = obs_vec(k);
      check($sformatf("ctl%0d", k), cap[k], exp_vec(k));
    end
    @(posedge clk);
    adv();
    #1;
    if (prog_mode) begin
      opcode = p_op[pc % 16];
      z = dp_z;
    end
  endtask

  task automatic prog_start();
    pc = 0; dp_z = 1'b0; prog_mode = 1;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    opcode = p_op[0]; z = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n_pw, n_sd, cnt_before, guard;
    for (int a = 0; a < 16; a++) set_prog(a, 6'b000111, 0, 0, 0, 0);
    set_prog(0,  6'b000100, 5, 0, 0, 0);
    set_prog(5,  6'b000000, 0, 0, 0, 2);
    set_prog(6,  6'b000000, 2, 0, 0, 1);
    set_prog(7,  6'b000000, 4, 0, 0, 3);
    set_prog(8,  6'b000000, 1, 0, 0, 4);
    set_prog(9,  6'b101000, 0, 2, 3, 2);
    set_prog(10, 6'b101100, 0, 1, 4, 1);
    set_prog(11, 6'b000110, 9, 0, 0, 0);
    set_prog(12, 6'b000100, 12, 0, 0, 0);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) check($sformatf("rst%0d", k), obs_vec(k), exp_vec(k));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    adv();
    #1;

    // Program run: 13 executed instructions, d1 stops on its budget of 5.
    prog_start();
    n_pw = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      n_pw += cap[1][4];
    end
    check("prog_cnt", 32'(cnt0), 32'd13);
    check("prog_r2", 32'(rf[2]), 32'd8);
    check("prog_r1", 32'(rf[1]), 32'd0);
    check("prog_pc", 32'(pc), 32'd12);
    check("prog_run", 32'(running[0]), 32'd1);
    check("budget_pw", 32'(n_pw), 32'd5);
    check("budget_cnt", 32'(cnt1), 32'd5);
    check("budget_idle", 32'(running[1]), 32'd0);
    check("sat_cnt", 32'(cnt2), 32'd7);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Stop in the cycle of the add: the add still commits.
    prog_start();
    guard = 0;
    while (pc != 9 && guard < 20) begin
      tick();
      guard++;
    end
    check("reach_add", 32'(pc), 32'd9);
    stop = 1'b1;
    tick();
    check("stop_add_we3", 32'(cap[0][9]), 32'd1);
    check("stop_add_pcwe", 32'(cap[0][4]), 32'd1);
    stop = 1'b0;
    tick();
    check("stop_idle", {30'b0, cap[0][3], cap[0][4]}, 32'd0);
    prog_mode = 0;

    // Held step executes exactly one instruction.
    opcode = 6'b000000;
    cnt_before = m_cnt[0];
    step = 1'b1;
    n_pw = 0; n_sd = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_pw += cap[0][4];
      n_sd += cap[0][0];
    end
    step = 1'b0;
    tick();
    n_sd += cap[0][0];
    check("step_pw", 32'(n_pw), 32'd1);
    check("step_done", 32'(n_sd), 32'd1);
    check("step_cnt", 32'(cnt0), 32'(cnt_before + 1));

    // Illegal opcode trap, ignored start, clear_err.
    opcode = 6'b000111;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    opcode = 6'b010000;
    tick();
    check("ill_gate", {29'b0, cap[0][9], cap[0][8], cap[0][4]}, 32'd0);
    start = 1'b1;
    tick();
    check("ill_flags", {30'b0, cap[0][2], cap[0][1]}, 32'd3);
    tick();
    check("err_start", {30'b0, cap[0][3], cap[0][2]}, 32'd1);
    start = 1'b0;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    tick();
    check("cleared", {29'b0, cap[0][3], cap[0][2], cap[0][1]}, 32'd0);

    // Reset asserted between edges during RUN.
    opcode = 6'b101000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    check("pre_rst_we3", 32'(we3[0]), 32'd1);
    reset = 1'b0;
    #1;
    for (int k = 0; k < NI; k++)
      check($sformatf("async_rst%0d", k), {29'b0, we3[k], wez[k], pc_we[k]}, 32'd0);
    check("async_cnt", 32'(cnt0), 32'd0);
    model_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    adv();
    #1;
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 15);
      if (r == 0) opcode = 6'(16 + $urandom_range(0, 15));
      else if (r < 8) opcode = 6'(32 + $urandom_range(0, 31));
      else opcode = 6'($urandom_range(0, 7));
      z = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 9) == 0);
      step = ($urandom_range(0, 3) == 0);
      clear_err = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
